// File: rtl/vdc_pkg.sv
// vdc_pkg: shared state encoding and power-up register table for the VDC init sequencer
package vdc_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_POLL_REQ, S_POLL_CHK, S_DATA, S_NEXT, S_DONE, S_ERR
  } vdc_seq_state_t;
  localparam logic [7:0] REG_FIRST = 8'd0;
  localparam logic [7:0] REG_R4 = 8'd4;
  localparam logic [7:0] REG_R7 = 8'd7;
  localparam logic [7:0] REG_R25 = 8'd25;
  localparam logic [4:0] LEN_BASE = 5'd29;
  localparam logic [4:0] LEN_R9 = 5'd30;
  // {reg, value}; R4/R7/R25 values are overridden by version/pal in the ROM
  localparam logic [15:0] INIT_TABLE [32] = '{
    16'h007E, 16'h0150, 16'h0266, 16'h0349, 16'h0427, 16'h0500, 16'h0619, 16'h0720,
    16'h0800, 16'h0907, 16'h0A20, 16'h0B07, 16'h0C00, 16'h0D00, 16'h0E00, 16'h0F00,
    16'h1408, 16'h1500, 16'h1678, 16'h1708, 16'h1820, 16'h1947, 16'h1AF0, 16'h1B00,
    16'h1C20, 16'h1D07, 16'h227D, 16'h2364, 16'h2405, 16'h25C0, 16'h0000, 16'h0000
  };
endpackage

// File: rtl/vdc_init_rom.sv
// vdc_init_rom: combinational lookup of the init table entry for a given index, chip version and timing
module vdc_init_rom
  import vdc_pkg::*;
(
  input  logic [4:0] index,
  input  logic [1:0] version,
  input  logic       pal,
  output logic [7:0] reg_num,
  output logic [7:0] value,
  output logic       last
);
  assign reg_num = INIT_TABLE[index][15:8];
  assign value = reg_num == REG_R4  ? (pal ? 8'h27 : 8'h20) :
                 reg_num == REG_R7  ? (pal ? 8'h20 : 8'h1D) :
                 reg_num == REG_R25 ? (version == 2'd0 ? 8'h40 : 8'h47) :
                 INIT_TABLE[index][7:0];
  assign last = index == (version == 2'd2 ? LEN_R9 : LEN_BASE) - 5'd1;
endmodule

// File: rtl/vdc_init_seq.sv
// vdc_init_seq: bus-master that writes the VDC power-up register table, polling ready before each data write
module vdc_init_seq
  import vdc_pkg::*;
#(
  parameter int POLL_LIMIT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [1:0] version,
  input  logic       pal,
  output logic       cs,
  output logic       rs,
  output logic       we,
  output logic [7:0] db_out,
  input  logic [7:0] db_in,
  output logic       active,
  output logic       done,
  output logic       error
);
  localparam logic [7:0] LIMIT = 8'(POLL_LIMIT);
  vdc_seq_state_t state;
  logic [4:0] idx;
  logic [7:0] poll_cnt;
  logic [1:0] ver_q;
  logic       pal_q;
  logic       last_q;
  logic [7:0] rom_reg, rom_value;
  logic       rom_last;
  logic       unused_db;
  assign unused_db = &{1'b0, db_in[6:0]};
  // NEXT looks one entry ahead so the following select can be registered directly
  vdc_init_rom u_rom (
    .index  (state == S_NEXT ? idx + 5'd1 : idx),
    .version(ver_q),
    .pal    (pal_q),
    .reg_num(rom_reg),
    .value  (rom_value),
    .last   (rom_last)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= S_IDLE;
      idx <= '0;
      poll_cnt <= '0;
      ver_q <= '0;
      pal_q <= 1'b0;
      last_q <= 1'b0;
      cs <= 1'b0;
      rs <= 1'b0;
      we <= 1'b0;
      db_out <= '0;
      active <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: if (start) begin
          state <= S_SEL;
          idx <= '0;
          ver_q <= version;
          pal_q <= pal;
          active <= 1'b1;
          done <= 1'b0;
          error <= 1'b0;
          cs <= 1'b1;
          we <= 1'b1;
          rs <= 1'b0;
          db_out <= REG_FIRST;
        end
        S_SEL: begin
          state <= S_POLL_REQ;
          poll_cnt <= '0;
          we <= 1'b0;
        end
        S_POLL_REQ: begin
          state <= S_POLL_CHK;
          cs <= 1'b0;
        end
        S_POLL_CHK: if (db_in[7]) begin
          state <= S_DATA;
          cs <= 1'b1;
          we <= 1'b1;
          rs <= 1'b1;
          db_out <= rom_value;
        end else if (poll_cnt + 8'd1 == LIMIT) begin
          state <= S_ERR;
          error <= 1'b1;
          active <= 1'b0;
          db_out <= '0;
        end else begin
          state <= S_POLL_REQ;
          poll_cnt <= poll_cnt + 8'd1;
          cs <= 1'b1;
        end
        S_DATA: begin
          state <= S_NEXT;
          last_q <= rom_last;
          cs <= 1'b0;
          we <= 1'b0;
          rs <= 1'b0;
        end
        S_NEXT: if (last_q) begin
          state <= S_DONE;
          done <= 1'b1;
          active <= 1'b0;
          db_out <= '0;
        end else begin
          state <= S_SEL;
          idx <= idx + 5'd1;
          cs <= 1'b1;
          we <= 1'b1;
          db_out <= rom_reg;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_vdc_init_seq.sv
// tb_vdc_init_seq: directed bench with a behavioural VDC register port model
module tb_vdc_init_seq;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, pal = 1'b0, start2 = 1'b0, clr = 1'b0;
  logic [1:0] version = 2'd0, zero2 = 2'd0;
  logic zero1 = 1'b0;
  logic [7:0] db_in = 8'h00, zero8 = 8'h00;
  logic cs, rs, we, active, done, error;
  logic [7:0] db_out;
  logic cs2, rs2, we2, active2, done2, error2;
  logic [7:0] db_out2;
  logic tb_cs = 1'b0, tb_rs = 1'b0, tb_we = 1'b0;
  logic [7:0] tb_db = 8'h00;
  logic bus_cs, bus_rs, bus_we;
  logic [7:0] bus_db;
  int checks = 0, failures = 0;
  int nr_reg = -1, nr_cnt = 0;
  logic [7:0] vaddr = 8'h00;
  logic [7:0] vregs [64];
  int stat_reads [64];
  logic [15:0] wr_q [$];
  int st2 = 0, wr2 = 0;

  always #5 clk = ~clk;

  assign bus_cs = active ? cs : tb_cs;
  assign bus_rs = active ? rs : tb_rs;
  assign bus_we = active ? we : tb_we;
  assign bus_db = active ? db_out : tb_db;

  vdc_init_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .version(version), .pal(pal),
    .cs(cs), .rs(rs), .we(we), .db_out(db_out), .db_in(db_in),
    .active(active), .done(done), .error(error)
  );

  vdc_init_seq #(.POLL_LIMIT(4)) dut_lim (
    .clk(clk), .reset_n(reset_n), .start(start2), .version(zero2), .pal(zero1),
    .cs(cs2), .rs(rs2), .we(we2), .db_out(db_out2), .db_in(zero8),
    .active(active2), .done(done2), .error(error2)
  );

  // VDC port model: select latch, status with optional not-ready replies, data register file
  always @(posedge clk) begin
    if (clr) begin
      wr_q.delete();
      for (int i = 0; i < 64; i++) stat_reads[i] = 0;
      st2 = 0;
      wr2 = 0;
    end else begin
      if (bus_cs && !bus_rs && bus_we) vaddr = bus_db;
      else if (bus_cs && !bus_rs && !bus_we) begin
        db_in <= (int'(vaddr) == nr_reg && stat_reads[vaddr[5:0]] < nr_cnt) ? 8'h00 : 8'h80;
        stat_reads[vaddr[5:0]]++;
      end else if (bus_cs && bus_rs && bus_we) begin
        vregs[vaddr[5:0]] = bus_db;
        wr_q.push_back({vaddr, bus_db});
      end else if (bus_cs && bus_rs && !bus_we) db_in <= vregs[vaddr[5:0]];
      if (cs2 && !rs2 && !we2) st2++;
      if (cs2 && rs2 && we2) wr2++;
    end
  end

  function automatic logic [15:0] exp_ent(input int i, input logic [1:0] v, input logic p);
    case (i)
      0: return 16'h007E;  1: return 16'h0150;  2: return 16'h0266;  3: return 16'h0349;
      4: return {8'h04, p ? 8'h27 : 8'h20};
      5: return 16'h0500;  6: return 16'h0619;
      7: return {8'h07, p ? 8'h20 : 8'h1D};
      8: return 16'h0800;  9: return 16'h0907;  10: return 16'h0A20; 11: return 16'h0B07;
      12: return 16'h0C00; 13: return 16'h0D00; 14: return 16'h0E00; 15: return 16'h0F00;
      16: return 16'h1408; 17: return 16'h1500; 18: return 16'h1678; 19: return 16'h1708;
      20: return 16'h1820;
      21: return {8'h19, v == 2'd0 ? 8'h40 : 8'h47};
      22: return 16'h1AF0; 23: return 16'h1B00; 24: return 16'h1C20; 25: return 16'h1D07;
      26: return 16'h227D; 27: return 16'h2364; 28: return 16'h2405; 29: return 16'h25C0;
      default: return 16'hFFFF;
    endcase
  endfunction

  task automatic clear_logs;
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  task automatic run(input logic [1:0] v, input logic p, output int n, output logic d0, output logic a0);
    version = v;
    pal = p;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    d0 = done;
    a0 = active;
    n = 0;
    while (!done && n < 400) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  task automatic rd(input logic [7:0] r, output logic [7:0] d);
    @(negedge clk) begin tb_cs = 1'b1; tb_we = 1'b1; tb_rs = 1'b0; tb_db = r; end
    @(negedge clk) begin tb_we = 1'b0; tb_rs = 1'b1; end
    @(negedge clk) begin tb_cs = 1'b0; tb_rs = 1'b0; d = db_in; end
  endtask

  task automatic test_table(input string name, input logic [1:0] v, input logic p, input int exp_n);
    int n, cnt;
    logic d0, a0;
    cnt = v == 2'd2 ? 30 : 29;
    clear_logs();
    run(v, p, n, d0, a0);
    checks++; if (d0 !== 1'b0) begin failures++; $display("FAIL %s done_cleared got %b exp 0", name, d0); end
    checks++; if (a0 !== 1'b1) begin failures++; $display("FAIL %s active_after_start got %b exp 1", name, a0); end
    checks++; if (n != exp_n) begin failures++; $display("FAIL %s done_latency got %0d exp %0d", name, n, exp_n); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL %s active_at_done got %b exp 0", name, active); end
    checks++; if (wr_q.size() != cnt) begin failures++; $display("FAIL %s write_count got %0d exp %0d", name, wr_q.size(), cnt); end
    for (int i = 0; i < cnt && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== exp_ent(i, v, p)) begin
        failures++;
        $display("FAIL %s entry%0d got %h exp %h", name, i, wr_q[i], exp_ent(i, v, p));
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({cs, rs, we, db_out, active, done, error} !== 14'd0) begin failures++; $display("FAIL reset_outputs got %h exp 0", {cs, rs, we, db_out, active, done, error}); end
    checks++; if ({cs2, active2, error2} !== 3'd0) begin failures++; $display("FAIL reset_lim got %b exp 000", {cs2, active2, error2}); end
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic test_pal_r8;
    logic [7:0] d;
    test_table("pal_r8", 2'd1, 1'b1, 145);
    rd(8'd0, d);
    checks++; if (d !== 8'h7E) begin failures++; $display("FAIL pal_r8 readback_r0 got %h exp 7e", d); end
    checks++; if (vregs[25] !== 8'h47) begin failures++; $display("FAIL pal_r8 r25 got %h exp 47", vregs[25]); end
  endtask

  task automatic test_ntsc_r7a;
    int c37;
    test_table("ntsc_r7a", 2'd0, 1'b0, 145);
    c37 = 0;
    foreach (wr_q[i]) if (wr_q[i][15:8] == 8'h25) c37++;
    checks++; if (c37 != 0 || stat_reads[37] != 0) begin failures++; $display("FAIL ntsc_r7a r37_access got %0d/%0d exp 0/0", c37, stat_reads[37]); end
    checks++; if (vregs[7] !== 8'h1D) begin failures++; $display("FAIL ntsc_r7a r7 got %h exp 1d", vregs[7]); end
  endtask

  task automatic test_r9;
    logic [7:0] d;
    test_table("r9", 2'd2, 1'b1, 150);
    checks++; if (wr_q.size() == 0 || wr_q[wr_q.size() - 1] !== 16'h25C0) begin failures++; $display("FAIL r9 last_write got %h exp 25c0", wr_q.size() ? wr_q[wr_q.size() - 1] : 16'h0); end
    rd(8'd37, d);
    checks++; if (d !== 8'hC0) begin failures++; $display("FAIL r9 readback_r37 got %h exp c0", d); end
  endtask

  task automatic test_poll_retry;
    int n, c12;
    logic d0, a0;
    nr_reg = 12;
    nr_cnt = 3;
    clear_logs();
    run(2'd1, 1'b1, n, d0, a0);
    nr_reg = -1;
    c12 = 0;
    foreach (wr_q[i]) if (wr_q[i][15:8] == 8'h0C) c12++;
    checks++; if (n != 151) begin failures++; $display("FAIL poll_retry done_latency got %0d exp 151", n); end
    checks++; if (stat_reads[12] != 4) begin failures++; $display("FAIL poll_retry r12_status_reads got %0d exp 4", stat_reads[12]); end
    checks++; if (c12 != 1) begin failures++; $display("FAIL poll_retry r12_writes got %0d exp 1", c12); end
    checks++; if (wr_q.size() != 29) begin failures++; $display("FAIL poll_retry write_count got %0d exp 29", wr_q.size()); end
  endtask

  task automatic test_poll_limit;
    int n;
    clear_logs();
    @(negedge clk) start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    n = 0;
    while (!error2 && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    checks++; if (n != 9) begin failures++; $display("FAIL poll_limit error_latency got %0d exp 9", n); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (error2 !== 1'b1) begin failures++; $display("FAIL poll_limit error got %b exp 1", error2); end
    checks++; if (st2 != 4) begin failures++; $display("FAIL poll_limit status_reads got %0d exp 4", st2); end
    checks++; if (wr2 != 0) begin failures++; $display("FAIL poll_limit data_writes got %0d exp 0", wr2); end
    checks++; if ({active2, cs2, done2} !== 3'b000) begin failures++; $display("FAIL poll_limit idle_bus got %b exp 000", {active2, cs2, done2}); end
  endtask

  task automatic test_reset_mid;
    int n;
    version = 2'd1;
    pal = 1'b1;
    clear_logs();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (!(cs && rs && we) && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    checks++; if (n != 3) begin failures++; $display("FAIL reset_mid data_cycle got %0d exp 3", n); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({cs, rs, we, db_out, active, done, error} !== 14'd0) begin failures++; $display("FAIL reset_mid async_outputs got %h exp 0", {cs, rs, we, db_out, active, done, error}); end
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (wr_q.size() != 0) begin failures++; $display("FAIL reset_mid aborted_write got %0d exp 0", wr_q.size()); end
  endtask

  task automatic test_back_to_back;
    int n;
    clear_logs();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (!done && n < 400) begin
      if (n == 20) start = 1'b1;
      if (n == 21) start = 1'b0;
      @(posedge clk);
      #1 n++;
    end
    checks++; if (n != 145) begin failures++; $display("FAIL back_to_back done_latency got %0d exp 145", n); end
    checks++; if (wr_q.size() != 29) begin failures++; $display("FAIL back_to_back write_count got %0d exp 29", wr_q.size()); end
    checks++; if (wr_q.size() == 0 || wr_q[0] !== 16'h007E) begin failures++; $display("FAIL back_to_back first_write got %h exp 007e", wr_q.size() ? wr_q[0] : 16'h0); end
  endtask

  initial begin
    test_reset();
    test_pal_r8();
    test_ntsc_r7a();
    test_r9();
    test_poll_retry();
    test_poll_limit();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
